// File: rtl/mem_sp_model.sv
// Single-port WIDTH x HEIGHT memory with MASK write lanes; optional trace under MEM_TRACE_EN.
// Latency: read data appears READ_LAT cycles after the accept edge; writes produce no response.
// Backpressure: rsp_valid && !rsp_ready freezes the whole read pipeline and drops req_ready.
module mem_sp_model #(
    parameter           TYPE     = "no",
    parameter           PROFILE  = "spit",
    parameter int       WIDTH    = 32,
    parameter int       HEIGHT   = 64,
    parameter int       MASK     = 4,
    parameter int       READ_LAT = 1,
    localparam int      AW       = (HEIGHT > 2) ? $clog2(HEIGHT) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [MASK-1:0]  req_wmask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             err_addr
);

    localparam int           LW       = WIDTH / MASK;
    localparam logic [AW:0]  HEIGHT_W = (AW+1)'(HEIGHT);
    localparam bit           TAGS_OK  = ($bits(TYPE) > 0) && ($bits(PROFILE) > 0);

    if (WIDTH < 1 || HEIGHT < 2) begin : g_bad_size
        $fatal(1, "mem_sp_model: WIDTH must be >= 1 and HEIGHT >= 2");
    end
    if (MASK < 1 || (WIDTH % MASK) != 0) begin : g_bad_mask
        $fatal(1, "mem_sp_model: WIDTH must be a multiple of MASK");
    end
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $fatal(1, "mem_sp_model: READ_LAT must be 1..4");
    end
    if (!TAGS_OK) begin : g_bad_tags
        $fatal(1, "mem_sp_model: TYPE and PROFILE tags must be non-empty");
    end

    logic [WIDTH-1:0]    mem [HEIGHT];
    logic [READ_LAT-1:0] stg_vld;
    logic [WIDTH-1:0]    stg_dat [READ_LAT];
    logic [WIDTH-1:0]    rd_word;
    logic                stall;
    logic                req_acc;
    logic                rd_acc;
    logic                wr_acc;
    logic                in_range;

    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = !stall;
    assign req_acc   = req_valid && req_ready;
    assign rd_acc    = req_acc && !req_write;
    assign wr_acc    = req_acc && req_write;
    assign in_range  = {1'b0, req_addr} < HEIGHT_W;
    assign rsp_valid = stg_vld[READ_LAT-1];
    assign rsp_rdata = stg_dat[READ_LAT-1];

    // Out-of-range reads return zero rather than touching the array.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem[req_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int i = 0; i < MASK; i++) begin
                if (req_wmask[i]) begin
                    mem[req_addr][i*LW +: LW] <= req_wdata[i*LW +: LW];
                end
            end
        end
    end

    // Stage data only moves with a valid token so the last stage holds its value while idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stg_vld  <= '0;
            err_addr <= 1'b0;
            for (int k = 0; k < READ_LAT; k++) begin
                stg_dat[k] <= '0;
            end
        end else begin
            if (req_acc && !in_range) begin
                err_addr <= 1'b1;
            end
            if (!stall) begin
                stg_vld[0] <= rd_acc;
                if (rd_acc) begin
                    stg_dat[0] <= rd_word;
                end
                for (int k = 1; k < READ_LAT; k++) begin
                    stg_vld[k] <= stg_vld[k-1];
                    if (stg_vld[k-1]) begin
                        stg_dat[k] <= stg_dat[k-1];
                    end
                end
            end
        end
    end

`ifdef MEM_TRACE_EN
    initial begin
        $display("%m: WIDTH=%0d HEIGHT=%0d MASK=%0d READ_LAT=%0d TYPE=%s PROFILE=%s",
                 WIDTH, HEIGHT, MASK, READ_LAT, TYPE, PROFILE);
    end

    always @(posedge clk) begin
        if (reset_n && req_acc) begin
            $display("%m %s %0h %0h %0h", req_write ? "W" : "R", req_addr, req_wdata, req_wmask);
        end
        if (reset_n && rsp_valid && rsp_ready) begin
            $display("%m RSP %0h", rsp_rdata);
        end
    end
`else
    // Trace disabled: the model is silent in simulation.
`endif

endmodule

// File: tb/tb_mem_sp_model.sv
// Randomised scoreboard bench for mem_sp_model (HEIGHT=10, READ_LAT=3) with directed corner cases.
module tb_mem_sp_model;

    localparam int WIDTH    = 32;
    localparam int HEIGHT   = 10;
    localparam int MASK     = 4;
    localparam int READ_LAT = 3;
    localparam int AW       = 4;

    logic             clk;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [MASK-1:0]  req_wmask;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             err_addr;

    mem_sp_model #(
        .TYPE("no"), .PROFILE("spit"),
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .MASK(MASK), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .err_addr(err_addr)
    );

    typedef struct {
        logic [WIDTH-1:0] dat;
        int               cyc;
        bit               strict;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] ref_mem [HEIGHT];
    bit               exp_err = 1'b0;
    bit               strict_mode = 1'b0;
    bit               rdy_mode = 1'b0;
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one handshake per negedge with valid && ready; compare against the queue head.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (rsp_valid === 1'b1 && sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 data %h, expected no response", rsp_rdata);
            end else if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.dat);
                if (e.strict) chk("rsp_latency", cyc - e.cyc, READ_LAT);
            end
            chk("err_addr", {31'b0, err_addr}, {31'b0, exp_err});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference behaviour of one accepted request.
    task automatic model_accept(input bit wr, input int a, input logic [WIDTH-1:0] d, input logic [MASK-1:0] m);
        exp_t e;
        if (wr) begin
            if (a < HEIGHT) begin
                for (int i = 0; i < MASK; i++)
                    if (m[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
            end
        end else begin
            e.dat    = (a < HEIGHT) ? ref_mem[a] : '0;
            e.cyc    = cyc;
            e.strict = strict_mode;
            sb_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit wr, input int a, input logic [WIDTH-1:0] d, input logic [MASK-1:0] m);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = AW'(a);
        req_wdata = d;
        req_wmask = m;
        while (!acc) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                model_accept(wr, a, d, m);
                acc = 1'b1;
            end else begin
                guard++;
                if (guard > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL req_accept_timeout: got req_ready=%b, expected 1 within 200 cycles", req_ready);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (acc && a >= HEIGHT) exp_err = 1'b1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] d0, d1;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_err_addr", {31'b0, err_addr}, 32'd0);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        strict_mode = 1'b1;
        for (int a = 0; a < HEIGHT; a++) send(1'b1, a, $urandom, 4'hF);

        // Full-mask write then read-after-write; partial-mask merge.
        send(1'b1, 5, 32'hDEADBEEF, 4'hF);
        send(1'b0, 5, '0, '0);
        send(1'b1, 5, 32'h11223344, 4'b0101);
        send(1'b0, 5, '0, '0);
        drain();
        chk("partial_mask_model", ref_mem[5], 32'hDE22BE44);

        // Throughput: four back-to-back reads with rsp_ready high.
        for (int a = 0; a < 4; a++) send(1'b1, a, 32'hA0 + a, 4'hF);
        for (int a = 0; a < 4; a++) begin
            chk("tp_req_ready", {31'b0, req_ready}, 32'd1);
            send(1'b0, a, '0, '0);
        end
        drain();

        // Backpressure: hold the first response, then release.
        strict_mode = 1'b0;
        d0 = ref_mem[0];
        d1 = ref_mem[1];
        send(1'b0, 0, '0, '0);
        send(1'b0, 1, '0, '0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata_hold", rsp_rdata, d0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_first", rsp_rdata, d0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_second_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_second_rdata", rsp_rdata, d1);
        @(posedge clk);
        #1;
        drain();

        // Out-of-range write/read, then an in-range read still sees old data.
        strict_mode = 1'b1;
        send(1'b1, 12, 32'hFFFF_FFFF, 4'hF);
        send(1'b0, 12, '0, '0);
        send(1'b0, 2, '0, '0);
        drain();
        chk("oor_err_sticky", {31'b0, err_addr}, 32'd1);

        // Randomised traffic with random response backpressure.
        strict_mode = 1'b0;
        rdy_mode    = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)), $urandom, 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode  = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Reset two cycles after a read is accepted: the read must vanish.
        strict_mode = 1'b1;
        rsp_ready   = 1'b1;
        send(1'b0, 3, '0, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        send(1'b0, 7, '0, '0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
